audio_note_sequencer: RTL and testbench

Upstream feeder for the four-channel square-wave audio unit. Software pushes note commands (channel, period, duration) into a small FIFO. The sequencer plays them back in order by writing the audio unit's period registers through its write port. When a note's duration expires and no command is queued, it mutes all four channels, so the CPU can queue a melody and stop polling.

---
 rtl/audio_note_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_audio_note_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_note_sequencer.sv
// Note sequencer feeding the four-channel square-wave audio unit.
// Handshake: a command is pushed on a rising edge where cmd_valid && cmd_ready;
// cmd_valid may rise at any time and cmd_ready never depends on cmd_valid.
// Notes are popped from a small FIFO and written to the audio unit's period
// registers. When the FIFO runs dry, all four channels are muted.
module audio_note_sequencer #(
  parameter int FIFO_DEPTH   = 8,
  parameter int TICK_CYCLES  = 100_000,
  parameter int PERIOD_WIDTH = 16,
  parameter int DUR_WIDTH    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_channel,
  input  logic [PERIOD_WIDTH-1:0]       cmd_period,
  input  logic [DUR_WIDTH-1:0]          cmd_duration,
  input  logic                          flush,
  output logic                          au_wenable,
  output logic [1:0]                    au_waddr,
  output logic [PERIOD_WIDTH-1:0]       au_wdata,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [1:0]                    fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int EW = 2 + PERIOD_WIDTH + DUR_WIDTH;
  localparam logic [PW-1:0] PRE_LOAD = PW'(TICK_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    MUTE  = 2'd3
  } state_t;

  state_t state, state_n;

  logic [EW-1:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             count;
  logic                    full, empty, push, pop;
  logic [EW-1:0]           head;
  logic [1:0]              head_ch;
  logic [PERIOD_WIDTH-1:0] head_period;

  logic [DUR_WIDTH-1:0]    note_dur;
  logic [PW-1:0]           prescaler;
  logic [DUR_WIDTH-1:0]    remaining;
  logic [1:0]              idx, idx_n;

  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign cmd_ready   = !full && !flush;
  assign push        = cmd_valid && cmd_ready;
  assign head        = mem[rd_ptr];
  assign head_ch     = head[EW-1 -: 2];
  assign head_period = head[DUR_WIDTH +: PERIOD_WIDTH];
  assign fifo_count  = count;
  assign busy        = (state != IDLE);
  assign fsm_state   = state;

  // FIFO storage: written only on an accepted push (push is already blocked by flush).
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_channel, cmd_period, cmd_duration};
  end

  // FIFO pointers and occupancy; flush empties the queue and drops any pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // State and mute index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= 2'd0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // Next-state logic and pop decision.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    pop     = 1'b0;
    if (flush) begin
      state_n = MUTE;
      idx_n   = 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            state_n = ISSUE;
          end
        end
        ISSUE: begin
          if (note_dur != '0) begin
            state_n = WAIT;
          end else if (!empty) begin
            pop     = 1'b1;
            state_n = ISSUE;
          end else begin
            state_n = MUTE;
            idx_n   = 2'd0;
          end
        end
        WAIT: begin
          if (prescaler == '0 && remaining == DUR_WIDTH'(1)) begin
            if (!empty) begin
              pop     = 1'b1;
              state_n = ISSUE;
            end else begin
              state_n = MUTE;
              idx_n   = 2'd0;
            end
          end
        end
        MUTE: begin
          if (idx == 2'd3) state_n = IDLE;
          else             idx_n   = idx + 2'd1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Note timing and registered audio-unit write port. Every entry into ISSUE
  // coincides with a pop, so the FIFO head is the note being written.
  always_ff @(posedge clk) begin
    if (rst) begin
      note_dur   <= '0;
      prescaler  <= '0;
      remaining  <= '0;
      au_wenable <= 1'b0;
      au_waddr   <= 2'd0;
      au_wdata   <= '0;
    end else begin
      if (pop) note_dur <= head[DUR_WIDTH-1:0];

      if (state == ISSUE && state_n == WAIT) begin
        prescaler <= PRE_LOAD;
        remaining <= note_dur;
      end else if (state == WAIT) begin
        if (prescaler == '0) begin
          prescaler <= PRE_LOAD;
          remaining <= remaining - DUR_WIDTH'(1);
        end else begin
          prescaler <= prescaler - PW'(1);
        end
      end

      au_wenable <= (state_n == ISSUE) || (state_n == MUTE);
      if (state_n == ISSUE) begin
        au_waddr <= head_ch;
        au_wdata <= head_period;
      end else if (state_n == MUTE) begin
        au_waddr <= idx_n;
        au_wdata <= '0;
      end else begin
        au_waddr <= 2'd0;
        au_wdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_audio_note_sequencer.sv
// Bench for audio_note_sequencer with TICK_CYCLES=4, FIFO_DEPTH=4.
// Expected audio-unit writes are queued as {addr,data} when commands are
// pushed and compared in order as au_wenable pulses appear.
module tb_audio_note_sequencer;

  localparam int DEPTH = 4;
  localparam int TICK  = 4;
  localparam int PW    = 16;
  localparam int DW    = 16;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_channel;
  logic [PW-1:0] cmd_period;
  logic [DW-1:0] cmd_duration;
  logic          flush;
  logic          au_wenable;
  logic [1:0]    au_waddr;
  logic [PW-1:0] au_wdata;
  logic          busy;
  logic [2:0]    fifo_count;
  logic [1:0]    fsm_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [17:0] exp_q[$];
  int          wr_cyc[$];

  audio_note_sequencer #(
    .FIFO_DEPTH(DEPTH), .TICK_CYCLES(TICK), .PERIOD_WIDTH(PW), .DUR_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_channel(cmd_channel), .cmd_period(cmd_period), .cmd_duration(cmd_duration),
    .flush(flush), .au_wenable(au_wenable), .au_waddr(au_waddr), .au_wdata(au_wdata),
    .busy(busy), .fifo_count(fifo_count), .fsm_state(fsm_state)
  );

  // Clock and reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Scoreboard: compare every write pulse against the head of exp_q
  always @(negedge clk) begin : monitor
    logic [17:0] want;
    if (au_wenable === 1'b1) begin
      wr_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write cyc=%0d got addr=%0d data=%0d, required no write",
                 cyc, au_waddr, au_wdata);
      end else begin
        want = exp_q.pop_front();
        if ({au_waddr, au_wdata} !== want) begin
          errors++;
          $display("FAIL write_data cyc=%0d got addr=%0d data=%0d, required addr=%0d data=%0d",
                   cyc, au_waddr, au_wdata, want[17:16], want[15:0]);
        end
      end
    end
  end

  // Driver: call at a negedge; returns at the negedge after the accepting edge.
  task automatic push_cmd(input logic [1:0] ch, input logic [15:0] per,
                          input logic [15:0] dur, input bit expect_wr, output int t);
    int guard;
    guard        = 0;
    cmd_valid    = 1'b1;
    cmd_channel  = ch;
    cmd_period   = per;
    cmd_duration = dur;
    #1;
    while (cmd_ready !== 1'b1 && guard < 300) begin
      @(negedge clk);
      #1;
      guard++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_timeout got cmd_ready=%b after %0d cycles, required 1", cmd_ready, guard);
      cmd_valid = 1'b0;
      t = -1;
    end else begin
      if (expect_wr) exp_q.push_back({ch, per});
      t = cyc + 1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic expect_mutes();
    for (int i = 0; i < 4; i++) exp_q.push_back({2'(i), 16'h0000});
  endtask

  task automatic wait_idle(output int idle_cyc);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!(busy === 1'b0 && fifo_count === 3'd0) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    idle_cyc = cyc;
    checks++;
    if (guard >= 1000) begin
      errors++;
      $display("FAIL idle_timeout got busy=%b fifo_count=%0d, required 0/0", busy, fifo_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; flush = 1'b0;
    cmd_channel = 2'd0; cmd_period = '0; cmd_duration = '0;
    repeat (3) @(negedge clk);
    checks++; if (au_wenable !== 1'b0) begin errors++; $display("FAIL rst_wenable got %b required 0", au_wenable); end
    checks++; if (au_waddr !== 2'd0) begin errors++; $display("FAIL rst_waddr got %0d required 0", au_waddr); end
    checks++; if (au_wdata !== 16'd0) begin errors++; $display("FAIL rst_wdata got %0d required 0", au_wdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b required 0", busy); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d required 0", fifo_count); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b required 1", cmd_ready); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d required 0", fsm_state); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_note();
    int t, ic;
    wr_cyc.delete();
    push_cmd(2'd1, 16'd10000, 16'd2, 1'b1, t);
    expect_mutes();
    wait_idle(ic);
    checks++;
    if (wr_cyc.size() != 5) begin
      errors++; $display("FAIL single_count got %0d writes required 5", wr_cyc.size());
    end else begin
      checks++; if (wr_cyc[0] != t + 1) begin errors++; $display("FAIL single_issue got cyc %0d required %0d", wr_cyc[0], t + 1); end
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (wr_cyc[i] != t + 9 + i) begin errors++; $display("FAIL single_mute%0d got cyc %0d required %0d", i - 1, wr_cyc[i], t + 9 + i); end
      end
    end
    checks++; if (ic != t + 14) begin errors++; $display("FAIL single_idle got cyc %0d required %0d", ic, t + 14); end
  endtask

  task automatic test_chord();
    int t0, t1, t2, ic;
    wr_cyc.delete();
    push_cmd(2'd0, 16'd10000, 16'd0, 1'b1, t0);
    push_cmd(2'd1, 16'd20000, 16'd0, 1'b1, t1);
    push_cmd(2'd2, 16'd20000, 16'd3, 1'b1, t2);
    expect_mutes();
    wait_idle(ic);
    checks++;
    if (wr_cyc.size() != 7) begin
      errors++; $display("FAIL chord_count got %0d writes required 7", wr_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_cyc[i] != t0 + 1 + i) begin errors++; $display("FAIL chord_issue%0d got cyc %0d required %0d", i, wr_cyc[i], t0 + 1 + i); end
      end
      for (int i = 3; i < 7; i++) begin
        checks++;
        if (wr_cyc[i] != t0 + 13 + i) begin errors++; $display("FAIL chord_mute%0d got cyc %0d required %0d", i - 3, wr_cyc[i], t0 + 13 + i); end
      end
    end
    checks++; if (ic != t0 + 20) begin errors++; $display("FAIL chord_idle got cyc %0d required %0d", ic, t0 + 20); end
  endtask

  task automatic test_back_to_back();
    int t, ic;
    wr_cyc.delete();
    push_cmd(2'd0, 16'd111, 16'd10, 1'b1, t);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) push_cmd(2'(i + 1), 16'(1001 + i), 16'd1, 1'b1, t);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b required 0", cmd_ready); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d required 4", fifo_count); end
    push_cmd(2'd1, 16'd1005, 16'd1, 1'b1, t);
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL refill_count got %0d required 4", fifo_count); end
    expect_mutes();
    wait_idle(ic);
    checks++;
    if (wr_cyc.size() != 10) begin
      errors++; $display("FAIL b2b_count got %0d writes required 10", wr_cyc.size());
    end else begin
      checks++; if (wr_cyc[1] - wr_cyc[0] != 41) begin errors++; $display("FAIL b2b_long_gap got %0d required 41", wr_cyc[1] - wr_cyc[0]); end
      for (int k = 2; k < 7; k++) begin
        checks++;
        if (wr_cyc[k] - wr_cyc[k-1] != 5) begin errors++; $display("FAIL b2b_gap%0d got %0d required 5", k, wr_cyc[k] - wr_cyc[k-1]); end
      end
      for (int k = 7; k < 10; k++) begin
        checks++;
        if (wr_cyc[k] - wr_cyc[k-1] != 1) begin errors++; $display("FAIL b2b_mute_gap%0d got %0d required 1", k, wr_cyc[k] - wr_cyc[k-1]); end
      end
    end
  endtask

  task automatic test_flush();
    int t, tf, ic;
    wr_cyc.delete();
    push_cmd(2'd2, 16'd500, 16'd10, 1'b1, t);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) push_cmd(2'(i + 1), 16'(7001 + i), 16'd2, 1'b0, t);
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got %0d required 3", fifo_count); end
    expect_mutes();
    flush = 1'b1;
    cmd_valid = 1'b1; cmd_channel = 2'd0; cmd_period = 16'd9999; cmd_duration = 16'd1;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b required 0", cmd_ready); end
    tf = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; cmd_valid = 1'b0;
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d required 0", fifo_count); end
    checks++; if (fsm_state !== 2'd3) begin errors++; $display("FAIL flush_state got %0d required 3", fsm_state); end
    wait_idle(ic);
    checks++;
    if (wr_cyc.size() != 5) begin
      errors++; $display("FAIL flush_writes got %0d writes required 5", wr_cyc.size());
    end else begin
      checks++; if (wr_cyc[1] != tf) begin errors++; $display("FAIL flush_mute0 got cyc %0d required %0d", wr_cyc[1], tf); end
      checks++; if (wr_cyc[4] != tf + 3) begin errors++; $display("FAIL flush_mute3 got cyc %0d required %0d", wr_cyc[4], tf + 3); end
    end
  endtask

  task automatic test_reset_in_mute();
    int t, t2;
    wr_cyc.delete();
    push_cmd(2'd1, 16'd300, 16'd0, 1'b1, t);
    for (int i = 0; i < 3; i++) exp_q.push_back({2'(i), 16'h0000});
    repeat (2) @(negedge clk);
    push_cmd(2'd2, 16'd700, 16'd5, 1'b0, t2);
    @(negedge clk);
    checks++; if (fsm_state !== 2'd3) begin errors++; $display("FAIL rm_state got %0d required 3", fsm_state); end
    checks++; if (au_waddr !== 2'd2) begin errors++; $display("FAIL rm_idx got %0d required 2", au_waddr); end
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL rm_count got %0d required 1", fifo_count); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (au_wenable !== 1'b0) begin errors++; $display("FAIL rm_wenable got %b required 0", au_wenable); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL rm_idle got %0d required 0", fsm_state); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rm_empty got %0d required 0", fifo_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b required 0", busy); end
    repeat (10) @(negedge clk);
    checks++; if (wr_cyc.size() != 4) begin errors++; $display("FAIL rm_writes got %0d writes required 4", wr_cyc.size()); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rm_pending got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_silent_note();
    int t, ic;
    wr_cyc.delete();
    push_cmd(2'd3, 16'd0, 16'd1, 1'b1, t);
    expect_mutes();
    wait_idle(ic);
    checks++;
    if (wr_cyc.size() != 5) begin
      errors++; $display("FAIL silent_count got %0d writes required 5", wr_cyc.size());
    end else begin
      checks++; if (wr_cyc[0] != t + 1) begin errors++; $display("FAIL silent_issue got cyc %0d required %0d", wr_cyc[0], t + 1); end
      checks++; if (wr_cyc[1] - wr_cyc[0] != 5) begin errors++; $display("FAIL silent_gap got %0d required 5", wr_cyc[1] - wr_cyc[0]); end
    end
    checks++; if (ic != t + 10) begin errors++; $display("FAIL silent_idle got cyc %0d required %0d", ic, t + 10); end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; flush = 1'b0;
    cmd_channel = 2'd0; cmd_period = '0; cmd_duration = '0;
    test_reset();
    test_single_note();
    test_chord();
    test_back_to_back();
    test_flush();
    test_reset_in_mute();
    test_silent_note();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL final_pending got %0d pending writes required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
